// File: rtl/sm3_pkg.sv
// SM3 shared types, sizes and word helpers.
// Used by the message-expansion stage and its word generator.
package sm3_pkg;

  localparam int INPT_DW   = 32;
  localparam int BLK_WORDS = 16;
  localparam int EXP_BEATS = 64;

  typedef enum logic {
    LOAD,
    EXPND
  } expnd_st_t;

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input int unsigned n
  );
    rotl32 = (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(
    input logic [31:0] x
  );
    p1 = x ^ rotl32(x, 15) ^ rotl32(x, 23);
  endfunction

endpackage

// File: rtl/sm3_expnd_wgen.sv
// SM3 expansion word generator.
// Next window word from taps 0, 3, 7, 10 and 13.
module sm3_expnd_wgen
  import sm3_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w3,
  input  logic [31:0] w7,
  input  logic [31:0] w10,
  input  logic [31:0] w13,
  output logic [31:0] w_new
);

  // Wj from W(j-16), W(j-13), W(j-9), W(j-6), W(j-3)
  always_comb begin
    w_new = p1(w0 ^ w7 ^ rotl32(w13, 15))
          ^ rotl32(w3, 7) ^ w10;
  end

endmodule

// File: rtl/sm3_expnd.sv
// SM3 message expansion: loads 16 words, then
// streams 64 (Wj, W'j) beats from a sliding window.
module sm3_expnd
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_otpt_d,
  input  logic        pad_otpt_vld,
  input  logic        pad_otpt_lst,
  output logic        pad_otpt_ena,
  input  logic        expnd_otpt_ena,
  output logic [31:0] expnd_otpt_wj,
  output logic [31:0] expnd_otpt_wjj,
  output logic        expnd_otpt_vld,
  output logic        expnd_otpt_lst
);

  localparam logic [3:0] LD_LAST = 4'(BLK_WORDS - 1);
  localparam logic [5:0] BT_LAST = 6'(EXP_BEATS - 1);

  if (INPT_DW != 32) begin : g_dw_chk
    $error("sm3_expnd: only 32-bit words are supported");
  end

  expnd_st_t   st_q;
  expnd_st_t   st_d;
  logic [3:0]  ld_cnt;
  logic [5:0]  bt_cnt;
  logic        lst_flg;
  logic [31:0] win [BLK_WORDS];
  logic [31:0] w_new;
  logic        pad_xfr;
  logic        out_xfr;

  assign pad_xfr = pad_otpt_vld & pad_otpt_ena;
  assign out_xfr = expnd_otpt_vld & expnd_otpt_ena;

  sm3_expnd_wgen u_wgen (
    .w0    (win[0]),
    .w3    (win[3]),
    .w7    (win[7]),
    .w10   (win[10]),
    .w13   (win[13]),
    .w_new (w_new)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= LOAD;
    else        st_q <= st_d;
  end

  // Next state: leave LOAD on 16th word, EXPND on 64th beat
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      LOAD:
        if (pad_xfr && ld_cnt == LD_LAST) st_d = EXPND;
      EXPND:
        if (out_xfr && bt_cnt == BT_LAST) st_d = LOAD;
    endcase
  end

  // Outputs: handshakes from state, beat data from window head
  always_comb begin
    pad_otpt_ena   = (st_q == LOAD);
    expnd_otpt_vld = (st_q == EXPND);
    expnd_otpt_wj  = win[0];
    expnd_otpt_wjj = win[0] ^ win[4];
    expnd_otpt_lst = lst_flg & (bt_cnt == BT_LAST);
  end

  // Window shifts on either a pad word or an output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_WORDS; i++)
        win[i] <= '0;
    end else if (pad_xfr | out_xfr) begin
      for (int i = 0; i < BLK_WORDS - 1; i++)
        win[i] <= win[i+1];
      win[BLK_WORDS-1] <= pad_xfr ? pad_otpt_d : w_new;
    end
  end

  // Word/beat counters and sticky last-block flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt  <= '0;
      bt_cnt  <= '0;
      lst_flg <= 1'b0;
    end else if (pad_xfr) begin
      ld_cnt  <= ld_cnt + 4'd1;
      lst_flg <= lst_flg | pad_otpt_lst;
    end else if (out_xfr) begin
      bt_cnt <= bt_cnt + 6'd1;
      if (bt_cnt == BT_LAST)
        lst_flg <= 1'b0;
    end
  end

endmodule
